bcd_stopwatch_counter: RTL
==========================

# bcd_stopwatch_counter

Four-digit BCD stopwatch counter that produces the 4-bit digit codes consumed by the per-digit BCD-to-seven-segment decoders. It sits directly upstream of those decoders: each `dN` output drives the 4-bit input of one decoder instance. A start/stop button toggles counting, and a clear input zeroes the count. An internal prescaler divides `clk` down to the count rate.

## Interface
- `TICK_DIV`, default 1000000: `clk` cycles per count step; legal range ≥ 2.
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start_stop` input 1: level from a debounced button; each rising edge toggles RUN/STOP.
- `clear` input 1: synchronous clear of count and state; level-sensitive.
- `down` input 1: count direction, 1 = decrement; present only with `BCD_DOWN_EN`.
- `d0` output 4: units digit, BCD 0–9.
- `d1` output 4: tens digit, BCD 0–9.
- `d2` output 4: hundreds digit, BCD 0–9.
- `d3` output 4: thousands digit, BCD 0–9.
- `running` output 1: high while in RUN.
- `overflow` output 1: one-cycle pulse on wrap 9999→0000 (or 0000→9999 when counting down).

## Operation
- **State machine:** two states, STOP and RUN. `running` is 1 exactly in RUN.
- **Edge detect:** `ss_q` registers `start_stop` every cycle; `rise = start_stop & ~ss_q`.
- **Toggle:** on `rise`, STOP→RUN or RUN→STOP.
- **Prescaler:** `presc`, width `$clog2(TICK_DIV)`.
  - Advances only in RUN.
  - In RUN, when `presc == TICK_DIV-1`: `presc` goes to 0 and `tick` asserts for that cycle. Otherwise `presc` increments by 1.
  - In STOP, `presc` holds its value, so a pause/resume keeps the partial period.
- **Count step** (on `tick`):
  - Up: `d0` increments; at 9 it goes to 0 and carries into `d1`, and likewise up through `d3`.
  - Down (`BCD_DOWN_EN` and `down`=1): `d0` decrements; at 0 it goes to 9 and borrows from `d1`, and likewise.
  - Digits never hold 10–15.
- **Wrap:** 9999→0000 (up) or 0000→9999 (down) sets `overflow`=1 for the next cycle only. Counting continues.
- **Clear:** `clear`=1 sets `d0`–`d3`=0, `presc`=0, state STOP, `overflow`=0. It does not touch `ss_q`.
- **Priority** (highest first): `rst` > `clear` > `tick`/`rise`.
  - A `rise` in the same cycle as `clear` is discarded.
  - A `tick` and a `rise` in the same cycle both take effect: the count step happens and the state toggles.
- **Reset values:** `d0`–`d3`=0, `running`=0 (STOP), `overflow`=0, `presc`=0.
  - `ss_q` resets to 1, so a button held through reset does not start the counter.
  - A reset during RUN returns to STOP at 0000 on the next edge.

## Timing
- **Start:** `rise` sampled at edge N → `running`=1 after edge N.
- **First step after clear:** `presc`=0 at start; `tick` is in the cycle ending at edge N+TICK_DIV. New digits become visible after that edge.
- **Stop:** `rise` at edge M → `running`=0 after M. Any tick already sampled at M still applies.
- **Output latency:** digits and `overflow` are registered; each changes 1 cycle after the `tick` cycle. No combinational path from inputs to outputs.
- **Step period:** exactly TICK_DIV cycles between successive steps in continuous RUN.

## Configuration
- **`BCD_DOWN_EN` defined:**
  - `down` port exists.
  - `down` is sampled in the `tick` cycle and selects decrement with 0000→9999 wrap and an `overflow` pulse.
- **`BCD_DOWN_EN` undefined:**
  - No `down` port.
  - Up-count only, with no down-count logic in the netlist.

## Test plan
- **Reset with button held:** `TICK_DIV`=4. Hold `start_stop`=1 through `rst` and release `rst` → `running`=0, digits stay 0000 for 20 cycles.
- **Start and step period:** `TICK_DIV`=4, `start_stop` 0→1 → `running`=1 next cycle; digits read 0001 four cycles later and 0010 forty cycles later.
- **Pause/resume:** toggle twice with 2 running cycles between presses → `presc` holds 2. After resume, the next step is 2 cycles later.
- **Up wrap:** preload to 9999 by running, tick → digits 0000, `overflow`=1 for exactly 1 cycle, `running` stays 1.
- **Clear vs. rise:** `clear`=1 and `rise` in the same cycle during RUN at 0123 → digits 0000, `running`=0, `presc`=0.
- **Down count (`BCD_DOWN_EN`):** from 0000, `down`=1, one tick → 9999 with an `overflow` pulse. From 1000, one tick → 0999.

Source files
------------

// File: rtl/bcd_stopwatch_counter_if.sv
// bcd_stopwatch_counter_if
// Control inputs and displayed digits of the four-digit BCD stopwatch.
//   start_stop : debounced button level; each rising edge toggles RUN/STOP
//   clear      : level-sensitive clear of count and state
//   down       : count direction, 1 = decrement (only with BCD_DOWN_EN)
//   d0..d3     : BCD digits, units to thousands
//   running    : high while counting
//   overflow   : one-cycle pulse on 9999->0000 (or 0000->9999) wrap
// Optional feature macro: BCD_DOWN_EN adds the down signal.
interface bcd_stopwatch_counter_if;
    logic       start_stop;
    logic       clear;
`ifdef BCD_DOWN_EN
    logic       down;
`endif
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       running;
    logic       overflow;

    modport master (
        output start_stop,
        output clear,
`ifdef BCD_DOWN_EN
        output down,
`endif
        input  d0,
        input  d1,
        input  d2,
        input  d3,
        input  running,
        input  overflow
    );

    modport slave (
        input  start_stop,
        input  clear,
`ifdef BCD_DOWN_EN
        input  down,
`endif
        output d0,
        output d1,
        output d2,
        output d3,
        output running,
        output overflow
    );
endinterface

// File: rtl/bcd_stopwatch_counter.sv
// bcd_stopwatch_counter
// Four-digit BCD stopwatch feeding the per-digit seven-segment decoders.
// A start/stop button toggles counting, clear zeroes the count, and an
// internal prescaler divides clk down to one count step per TICK_DIV cycles.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bcd_stopwatch_counter_if.slave (start_stop, clear, [down],
//          d0..d3, running, overflow)
// Parameter TICK_DIV (>= 2): clk cycles per count step.
// Optional feature macro: BCD_DOWN_EN enables down-counting via bus.down.
//
// state   | meaning
// --------+-------------------------------------------
// ST_STOP | paused; prescaler and digits hold
// ST_RUN  | prescaler advancing, digits step on tick
module bcd_stopwatch_counter #(
    parameter int TICK_DIV = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    bcd_stopwatch_counter_if.slave  bus
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            ss_q;
    logic            rise;
    logic            tick;
    logic [PW-1:0]   presc;
    logic [3:0][3:0] dig_q;
    logic [3:0][3:0] dig_step;
    logic            wrap;
    logic            carry;
    logic            ovf_q;

    assign rise = bus.start_stop & ~ss_q;
    assign tick = (state == ST_RUN) && (presc == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // clear wins over a simultaneous rise; a tick never blocks a toggle
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = ST_STOP;
        end else if (rise) begin
            state_nxt = (state == ST_RUN) ? ST_STOP : ST_RUN;
        end
    end

    // Ripple carry/borrow across the digits; carry out of d3 marks the wrap.
    always_comb begin
        dig_step = dig_q;
        carry    = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef BCD_DOWN_EN
            if (carry) begin
                if (bus.down) begin
                    if (dig_q[i] == 4'd0) begin
                        dig_step[i] = 4'd9;
                    end else begin
                        dig_step[i] = dig_q[i] - 4'd1;
                        carry       = 1'b0;
                    end
                end else begin
                    if (dig_q[i] == 4'd9) begin
                        dig_step[i] = 4'd0;
                    end else begin
                        dig_step[i] = dig_q[i] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
`else
            if (carry) begin
                if (dig_q[i] == 4'd9) begin
                    dig_step[i] = 4'd0;
                end else begin
                    dig_step[i] = dig_q[i] + 4'd1;
                    carry       = 1'b0;
                end
            end
`endif
        end
        wrap = carry;
    end

    // ss_q resets high so a button held through reset is not seen as a press;
    // clear leaves it alone so the edge detector stays consistent.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_q  <= 1'b1;
            presc <= '0;
            dig_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ss_q <= bus.start_stop;
            if (bus.clear) begin
                presc <= '0;
                dig_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= tick & wrap;
                if (state == ST_RUN) begin
                    presc <= tick ? '0 : presc + PW'(1);
                end
                if (tick) begin
                    dig_q <= dig_step;
                end
            end
        end
    end

    assign bus.d0       = dig_q[0];
    assign bus.d1       = dig_q[1];
    assign bus.d2       = dig_q[2];
    assign bus.d3       = dig_q[3];
    assign bus.running  = (state == ST_RUN);
    assign bus.overflow = ovf_q;
endmodule
